// File: rtl/processor_pkg.sv
`default_nettype none
// ============================================================================
// processor_pkg : shared fetch-stage types and constants
// Rev 1.0
// ============================================================================
package processor_pkg;

  localparam int unsigned WORD_WIDTH = 32;

  localparam logic [WORD_WIDTH-1:0] PC_STEP_DEFAULT = 32'd1;

  // 2'd3 is unused and recovers to S_ADDR
  typedef enum logic [1:0] {
    S_ADDR = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage : processor_pkg
`default_nettype wire

// File: rtl/pc_register.sv
`default_nettype none
// ============================================================================
// pc_register : program counter with reset load, redirect load and increment
// Rev 1.0
// ============================================================================
module pc_register
  import processor_pkg::*;
#(
  parameter logic [WORD_WIDTH-1:0] RESET_PC = 32'd0,
  parameter logic [WORD_WIDTH-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [WORD_WIDTH-1:0] load_pc,
  input  logic                  inc_en,
  output logic [WORD_WIDTH-1:0] pc
);

  logic [WORD_WIDTH-1:0] pc_d;
  logic [WORD_WIDTH-1:0] pc_q;

  // Redirect wins over increment; the sum wraps silently at 2^32
  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = load_pc;
    end else if (inc_en) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule : pc_register
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : multi-cycle instruction fetch with valid/ready hand-off to decode
// Rev 1.0
// ============================================================================
module fetch_unit
  import processor_pkg::*;
#(
  parameter logic [WORD_WIDTH-1:0] RESET_PC    = 32'd0,
  parameter logic [WORD_WIDTH-1:0] PC_STEP     = PC_STEP_DEFAULT,
  parameter int unsigned           MEM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [WORD_WIDTH-1:0] addressBus,
  input  logic [WORD_WIDTH-1:0] instructionIn,
  output logic [WORD_WIDTH-1:0] instructionReg,
  output logic [WORD_WIDTH-1:0] pcOut,
  output logic                  irValid,
  input  logic                  irReady,
  input  logic                  redirectValid,
  input  logic [WORD_WIDTH-1:0] redirectTarget,
  input  logic                  halt
);

  localparam logic [3:0] WAIT_INIT = 4'(MEM_LATENCY - 1);

  fetch_state_e          state_d, state_q;
  logic [3:0]            wait_cnt_d, wait_cnt_q;
  logic                  ir_valid_d, ir_valid_q;
  logic [WORD_WIDTH-1:0] instr_d, instr_q;
  logic [WORD_WIDTH-1:0] pc_out_d, pc_out_q;
  logic                  pc_load;
  logic                  pc_inc;
  logic [WORD_WIDTH-1:0] pc;

  pc_register #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_register (
    .clock   (clock),
    .reset   (reset),
    .load_en (pc_load),
    .load_pc (redirectTarget),
    .inc_en  (pc_inc),
    .pc      (pc)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ir_valid_d = ir_valid_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;

    case (state_q)
      S_ADDR: begin
        if (redirectValid) begin
          pc_load = 1'b1;
        end else if (!halt) begin
          wait_cnt_d = WAIT_INIT;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirectValid) begin
          pc_load = 1'b1;
          state_d = S_ADDR;
        end else if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else begin
          instr_d    = instructionIn;
          pc_out_d   = pc;
          pc_inc     = 1'b1;
          ir_valid_d = 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        // A redirect either coincides with acceptance or drops the held word
        if (irReady || redirectValid) begin
          pc_load    = redirectValid;
          ir_valid_d = 1'b0;
          state_d    = S_ADDR;
        end
      end
      default: begin
        ir_valid_d = 1'b0;
        state_d    = S_ADDR;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_ADDR;
      wait_cnt_q <= 4'd0;
      ir_valid_q <= 1'b0;
      instr_q    <= '0;
      pc_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ir_valid_q <= ir_valid_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
    end
  end

  assign addressBus     = pc;
  assign instructionReg = instr_q;
  assign pcOut          = pc_out_q;
  assign irValid        = ir_valid_q;

endmodule : fetch_unit
`default_nettype wire
